// File: rtl/uart_term_pkg.sv
// Shared types and constants for the oversampled UART receive terminal.
// Imported by the receiver top; the FIFO is type-agnostic.
package uart_term_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_EVEN     = 2'd1,
        PAR_ODD      = 2'd2,
        PAR_NONE_ALT = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Three votes centred on the middle of the bit; the last one is the decision point.
    localparam int VOTE_SPREAD = 1;

    function automatic int votePoint(input int oversample, input int idx);
        return oversample / 2 - VOTE_SPREAD + idx * VOTE_SPREAD;
    endfunction

endpackage

// File: rtl/uart_rx_term_if.sv
// Configuration, serial input and receive-FIFO read port of the UART receive terminal.
// The slave side is the receiver; the master side configures it and drains the FIFO.
interface uart_rx_term_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
);
    logic                          en;
    logic [DIV_W-1:0]              clk_div;
    logic [1:0]                    parity_mode;
    logic                          stop2;
    logic                          rx;
    logic                          rd;
    logic                          err_clr;
    logic [DATA_BITS-1:0]          rdata;
    logic                          rvalid;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          busy;
    logic                          parity_err;
    logic                          frame_err;
    logic                          overrun;

    modport master (
        output en, clk_div, parity_mode, stop2, rx, rd, err_clr,
        input  rdata, rvalid, level, busy, parity_err, frame_err, overrun
    );

    modport slave (
        input  en, clk_div, parity_mode, stop2, rx, rd, err_clr,
        output rdata, rvalid, level, busy, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; the head is always on rdata_o while not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             doPush, doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign level_o = wrPtr_q - rdPtr_q;
    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push to a full FIFO still fits.
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    assign rdPtr_d = doPop ? rdPtr_q + 1'b1 : rdPtr_q;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

endmodule

// File: rtl/uart_rx_term.sv
// UART receive channel: synchroniser, oversample tick generator, majority-vote bit FSM,
// sticky error flags and a FWFT receive FIFO, all in the HCLK domain.
module uart_rx_term
    import uart_term_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    uart_rx_term_if.slave bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SAMP_A    = SW'(votePoint(OVERSAMPLE, 0));
    localparam logic [SW-1:0] SAMP_B    = SW'(votePoint(OVERSAMPLE, 1));
    localparam logic [SW-1:0] SAMP_C    = SW'(votePoint(OVERSAMPLE, 2));
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, rxPrev_q;
    logic [DIV_W-1:0]     divCnt_q, divCnt_d;
    logic [SW-1:0]        sampCnt_q, sampCnt_d;
    logic [BW-1:0]        bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           vote_q, vote_d;
    logic                 stopIdx_q, stopIdx_d;
    logic                 parityBad_q, parityBad_d;
    logic                 stopBad_q, stopBad_d;
    logic                 parityErr_q, frameErr_q, overrun_q;
    logic                 rxFall, tickRun, tick, decide, bitEnd, bitVal, parityOn;
    logic                 push, parSet, frmSet, ovrSet;
    logic                 fifoFull, fifoEmpty;
    parity_e              parMode;

    assign parMode  = parity_e'(bus.parity_mode);
    assign parityOn = (parMode == PAR_EVEN) || (parMode == PAR_ODD);
    assign rxFall   = rxPrev_q & ~sync2_q;
    assign tickRun  = bus.en && (state_q != ST_IDLE);
    assign tick     = tickRun && (divCnt_q == bus.clk_div);
    assign decide   = tick && (sampCnt_q == SAMP_C);
    assign bitEnd   = tick && (sampCnt_q == SAMP_LAST);
    assign bitVal   = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);
    assign divCnt_d = (!tickRun || tick) ? '0 : divCnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sampCnt_d   = sampCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        vote_d      = vote_q;
        stopIdx_d   = stopIdx_q;
        parityBad_d = parityBad_q;
        stopBad_d   = stopBad_q;
        push        = 1'b0;
        parSet      = 1'b0;
        frmSet      = 1'b0;
        if (tick) begin
            sampCnt_d = bitEnd ? '0 : sampCnt_q + 1'b1;
            if (sampCnt_q == SAMP_A) vote_d[0] = sync2_q;
            if (sampCnt_q == SAMP_B) vote_d[1] = sync2_q;
        end
        case (state_q)
            ST_IDLE: begin
                sampCnt_d   = '0;
                bitCnt_d    = '0;
                stopIdx_d   = 1'b0;
                parityBad_d = 1'b0;
                stopBad_d   = 1'b0;
                if (bus.en && rxFall) state_d = ST_START;
            end
            ST_START: begin
                if (decide && bitVal) state_d = ST_IDLE;
                else if (bitEnd)      state_d = ST_DATA;
            end
            ST_DATA: begin
                if (decide) shift_d = {bitVal, shift_q[DATA_BITS-1:1]};
                if (bitEnd) begin
                    if (bitCnt_q == LAST_BIT) begin
                        bitCnt_d = '0;
                        state_d  = parityOn ? ST_PARITY : ST_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) parityBad_d = ((^shift_q) ^ bitVal) != (parMode == PAR_ODD);
                if (bitEnd) state_d = ST_STOP;
            end
            ST_STOP: begin
                // The last stop bit completes the frame at its decision point, not its end.
                if (decide) begin
                    if (!bus.stop2 || stopIdx_q) begin
                        frmSet  = stopBad_q | ~bitVal;
                        parSet  = parityBad_q;
                        push    = !(stopBad_q | ~bitVal) && !parityBad_q;
                        state_d = ST_IDLE;
                    end else begin
                        stopBad_d = ~bitVal;
                    end
                end
                if (bitEnd) stopIdx_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bus.en) state_d = ST_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rxPrev_q    <= 1'b1;
            state_q     <= ST_IDLE;
            divCnt_q    <= '0;
            sampCnt_q   <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            vote_q      <= '0;
            stopIdx_q   <= 1'b0;
            parityBad_q <= 1'b0;
            stopBad_q   <= 1'b0;
        end else begin
            sync1_q     <= bus.rx;
            sync2_q     <= sync1_q;
            rxPrev_q    <= sync2_q;
            state_q     <= state_d;
            divCnt_q    <= divCnt_d;
            sampCnt_q   <= sampCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            vote_q      <= vote_d;
            stopIdx_q   <= stopIdx_d;
            parityBad_q <= parityBad_d;
            stopBad_q   <= stopBad_d;
        end
    end

    // Sticky flags: a set event in the same cycle as err_clr wins.
    assign ovrSet = push && fifoFull && !(bus.rd && !fifoEmpty);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (parSet)           parityErr_q <= 1'b1;
            else if (bus.err_clr) parityErr_q <= 1'b0;
            if (frmSet)           frameErr_q  <= 1'b1;
            else if (bus.err_clr) frameErr_q  <= 1'b0;
            if (ovrSet)           overrun_q   <= 1'b1;
            else if (bus.err_clr) overrun_q   <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .push_i  (push),
        .pop_i   (bus.rd),
        .wdata_i (shift_q),
        .rdata_o (bus.rdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (bus.level)
    );

    assign bus.rvalid     = !fifoEmpty;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.parity_err = parityErr_q;
    assign bus.frame_err  = frameErr_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_term.sv
// Self-checking bench for uart_rx_term: a frame table plus hand-written sequences for
// false start, FIFO overrun, pop-and-push while full and mid-frame reset.
module tb_uart_rx_term;
    localparam int OS    = 16;
    localparam int DEPTH = 16;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    int   clkDiv     = 9;
    logic [7:0] sb[$];

    uart_rx_term_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_W(16)) bus ();

    uart_rx_term #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (16)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [7:0] data;
        logic [1:0] parMode;
        int         parBit;
        logic       stopA;
        logic       stopB;
        bit         useStop2;
        bit         expPush;
        bit         expPar;
        bit         expFrm;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        bus.rx = b;
        repeat ((clkDiv + 1) * OS) @(negedge HCLK);
    endtask

    // Drives one frame; parBit < 0 means no parity bit on the line.
    task automatic applyStimulus(input logic [7:0] data, input int parBit, input logic stopA,
                                 input logic stopB, input bit useStop2);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        if (parBit >= 0) driveBit(parBit[0]);
        driveBit(stopA);
        if (useStop2) driveBit(stopB);
        bus.rx = 1'b1;
    endtask

    task automatic pulseErrClr();
        bus.err_clr = 1'b1;
        @(negedge HCLK);
        bus.err_clr = 1'b0;
    endtask

    task automatic readAndCheck(input string name);
        logic [7:0] exp;
        int waitCyc = 0;
        while (!bus.rvalid && waitCyc < 50) begin
            @(negedge HCLK);
            waitCyc++;
        end
        checkOutput({name, "_rvalid"}, bus.rvalid, 1);
        checkOutput({name, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (bus.rvalid && sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput({name, "_rdata"}, bus.rdata, exp);
            bus.rd = 1'b1;
            @(negedge HCLK);
            bus.rd = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pushEdge;
        int modelLevel;
        bit expOverrun;

        bus.en = 1'b1;
        bus.clk_div = 16'(clkDiv);
        bus.parity_mode = 2'd0;
        bus.stop2 = 1'b0;
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        bus.err_clr = 1'b0;

        vecs[0]  = '{8'h48, 2'd0, -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 2'd1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'hA5, 2'd1,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h3C, 2'd0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h3C, 2'd0, -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h5A, 2'd2,  1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h0F, 2'd2,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{8'hC3, 2'd0, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h99, 2'd0, -1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'hFF, 2'd0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{8'h33, 2'd3, -1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge HCLK);
        checkOutput("reset_rdata", bus.rdata, 0);
        checkOutput("reset_rvalid", bus.rvalid, 0);
        checkOutput("reset_level", bus.level, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_parity_err", bus.parity_err, 0);
        checkOutput("reset_frame_err", bus.frame_err, 0);
        checkOutput("reset_overrun", bus.overrun, 0);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);

        for (int i = 0; i < 11; i++) begin
            bus.parity_mode = vecs[i].parMode;
            bus.stop2 = vecs[i].useStop2;
            pulseErrClr();
            checkOutput($sformatf("v%0d_clr_parity_err", i), bus.parity_err, 0);
            checkOutput($sformatf("v%0d_clr_frame_err", i), bus.frame_err, 0);
            if (vecs[i].expPush) sb.push_back(vecs[i].data);
            applyStimulus(vecs[i].data, vecs[i].parBit, vecs[i].stopA, vecs[i].stopB, vecs[i].useStop2);
            repeat (4) @(negedge HCLK);
            checkOutput($sformatf("v%0d_busy", i), bus.busy, 0);
            checkOutput($sformatf("v%0d_parity_err", i), bus.parity_err, 32'(vecs[i].expPar));
            checkOutput($sformatf("v%0d_frame_err", i), bus.frame_err, 32'(vecs[i].expFrm));
            checkOutput($sformatf("v%0d_level", i), bus.level, 32'(vecs[i].expPush));
            checkOutput($sformatf("v%0d_overrun", i), bus.overrun, 0);
            if (vecs[i].expPush) begin
                readAndCheck($sformatf("v%0d", i));
                checkOutput($sformatf("v%0d_rvalid_after_rd", i), bus.rvalid, 0);
            end
        end

        // False start: low for three ticks only.
        bus.parity_mode = 2'd0;
        bus.stop2 = 1'b0;
        pulseErrClr();
        bus.rx = 1'b0;
        repeat (2) @(negedge HCLK);
        checkOutput("false_start_busy_early", bus.busy, 0);
        @(negedge HCLK);
        checkOutput("false_start_busy_3clk", bus.busy, 1);
        repeat (3 * (clkDiv + 1) - 3) @(negedge HCLK);
        bus.rx = 1'b1;
        repeat ((clkDiv + 1) * OS) @(negedge HCLK);
        checkOutput("false_start_busy_end", bus.busy, 0);
        checkOutput("false_start_level", bus.level, 0);
        checkOutput("false_start_parity_err", bus.parity_err, 0);
        checkOutput("false_start_frame_err", bus.frame_err, 0);

        // FIFO overrun: 17 back-to-back frames without reads.
        clkDiv = 3;
        bus.clk_div = 16'(clkDiv);
        modelLevel = 0;
        expOverrun = 1'b0;
        for (int b = 0; b < 17; b++) begin
            if (modelLevel < DEPTH) begin
                sb.push_back(8'(b));
                modelLevel++;
            end else begin
                expOverrun = 1'b1;
            end
            applyStimulus(8'(b), -1, 1'b1, 1'b1, 1'b0);
        end
        repeat (4) @(negedge HCLK);
        checkOutput("ovr_level", bus.level, 32'(modelLevel));
        checkOutput("ovr_overrun", bus.overrun, 32'(expOverrun));
        for (int k = 0; k < DEPTH; k++) readAndCheck($sformatf("ovr_rd%0d", k));
        checkOutput("ovr_rvalid_drained", bus.rvalid, 0);
        pulseErrClr();
        checkOutput("ovr_cleared", bus.overrun, 0);

        // Fill again, then pop in the very cycle the 17th word is pushed.
        for (int b = 0; b < 16; b++) begin
            sb.push_back(8'(b));
            applyStimulus(8'(b), -1, 1'b1, 1'b1, 1'b0);
        end
        void'(sb.pop_front());
        sb.push_back(8'h10);
        // Push edge: 3 HCLK to START, then decision sample of the stop bit (bit 9, sample OS/2+1).
        pushEdge = 3 + ((1 + 8) * OS + OS / 2 + 1 + 1) * (clkDiv + 1);
        fork
            applyStimulus(8'h10, -1, 1'b1, 1'b1, 1'b0);
            begin
                repeat (pushEdge - 1) @(posedge HCLK);
                @(negedge HCLK);
                bus.rd = 1'b1;
                @(negedge HCLK);
                bus.rd = 1'b0;
            end
        join
        repeat (4) @(negedge HCLK);
        checkOutput("popush_overrun", bus.overrun, 0);
        checkOutput("popush_level", bus.level, DEPTH);
        for (int k = 0; k < DEPTH; k++) readAndCheck($sformatf("popush_rd%0d", k));
        checkOutput("popush_rvalid_drained", bus.rvalid, 0);

        // Mid-frame reset with a word already queued.
        clkDiv = 9;
        bus.clk_div = 16'(clkDiv);
        sb.push_back(8'h55);
        applyStimulus(8'h55, -1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge HCLK);
        checkOutput("prereset_level", bus.level, 1);
        fork
            applyStimulus(8'h7E, -1, 1'b1, 1'b1, 1'b0);
            begin
                repeat (4 * (clkDiv + 1) * OS) @(negedge HCLK);
                checkOutput("midframe_busy", bus.busy, 1);
                HRESETn = 1'b0;
                #1;
                checkOutput("midrst_rdata", bus.rdata, 0);
                checkOutput("midrst_rvalid", bus.rvalid, 0);
                checkOutput("midrst_level", bus.level, 0);
                checkOutput("midrst_busy", bus.busy, 0);
                checkOutput("midrst_parity_err", bus.parity_err, 0);
                checkOutput("midrst_frame_err", bus.frame_err, 0);
                checkOutput("midrst_overrun", bus.overrun, 0);
            end
        join
        sb.delete();
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        sb.push_back(8'h81);
        applyStimulus(8'h81, -1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge HCLK);
        readAndCheck("postrst");
        checkOutput("postrst_level", bus.level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_term.md
# uart_rx_term

Parametrised UART receive channel with oversampled majority-vote bit detection, optional parity, one or two stop bits, error flags and a first-word-fall-through receive FIFO. It generalises the fixed 8N1 serial terminal used on UART0 TX. It is synthesisable, so the same block can sit in the SoC as a UART RX front end or in the bench as a checker. It runs entirely in the HCLK domain.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, ticks per bit, even, ≥8
- FIFO_DEPTH, 16, receive FIFO entries, power of 2, ≥2
- DIV_W, 16, width of clk_div
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous, active-low reset
- en  in  1  receiver enable
- clk_div  in  DIV_W  HCLK cycles per oversample tick, minus 1
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 treated as none
- stop2  in  1  expect two stop bits
- rx  in  1  asynchronous serial input, idle high
- rd  in  1  pop FIFO head
- err_clr  in  1  clear sticky error flags
- rdata  out  DATA_BITS  FIFO head, valid when rvalid
- rvalid  out  1  FIFO not empty
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  FSM not in IDLE
- parity_err, frame_err, overrun  out  1 each  sticky error flags

## Operation
- rx passes through a 2-FF synchroniser; both flops reset to 1.
- Tick generator: counter runs 0..clk_div and pulses tick on wrap. It is held at 0 while en=0 or the FSM is in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised falling edge with en=1.
  - In every bit state, the sample count runs 0..OVERSAMPLE-1. The bit value is the majority of samples OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, decided at sample OVERSAMPLE/2+1.
  - START: a decided 1 is a false start and returns to IDLE with no flag. Otherwise go to DATA at the bit end.
  - DATA: shift in LSB first, DATA_BITS bits. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: even means the XOR of the data bits and the parity bit is 0; odd means it is 1.
  - STOP: the frame completes at the decision point of the last stop bit, with no wait for the bit end; the FSM returns to IDLE. With stop2, the first stop bit runs a full bit period.
- Frame outcome:
  - Any stop bit decided 0: frame_err is set and the word is discarded.
  - Parity mismatch: parity_err is set and the word is discarded.
  - Both errors together: both flags are set.
  - Clean frame: push to the FIFO.
- FIFO:
  - Push while full sets overrun and drops the incoming word; existing contents are untouched.
  - Push and rd together while full: pop then push, no overrun.
  - rd while empty is ignored.
- Flags: err_clr clears all three flags. A set event in the same cycle wins.
- en=0: FSM goes to IDLE and the tick counter clears. FIFO and flags are retained.
- clk_div, parity_mode and stop2 may only change while busy=0. Otherwise behaviour is undefined.

## Timing
- Reset values: rdata 0, rvalid 0, level 0, busy 0, all flags 0, FSM IDLE.
- Falling edge on rx to busy=1: 3 HCLK.
- Bit period = (clk_div+1)·OVERSAMPLE HCLK cycles.
- Push happens on the HCLK edge after the final stop-bit decision tick. rvalid and level update on that edge.
- rd pops on the clock edge. The new head is visible on rdata the following cycle, with no extra latency.
- A new start edge is accepted from the cycle after the FSM returns to IDLE, so back-to-back frames are supported.
- Reset asserted mid-frame clears everything asynchronously. The next full frame after release is received normally.

## Structure
- Shared package uart_term_pkg:
  - enum for parity_mode
  - FSM state enum
  - localparam for the majority sample points
- Sub-module uart_rx_fifo: parametrised FWFT FIFO with push/pop/full/empty/level, using ptr width $clog2(FIFO_DEPTH)+1.
- Synchroniser, tick generator, FSM and flags stay in the top module.

## Test plan
1. clk_div=9 (160 HCLK per bit), 8N1, send 0x48 -> rvalid=1, rdata=0x48, level=1. After rd: rvalid=0.
2. parity_mode=1, send 0xA5 with parity bit 1 -> parity_err=1, level=0. Then send 0xA5 with parity bit 0 -> rdata=0xA5.
3. Send 0x3C with stop bit 0 -> frame_err=1, no push. Then err_clr=1 -> frame_err=0. Then send a valid 0x3C -> rdata=0x3C.
4. rx low for 3 ticks then high -> busy returns to 0 within one bit time, level=0, no flags.
5. FIFO_DEPTH=16, send 17 bytes 0x00..0x10 with no rd -> level=16, overrun=1, reads return 0x00..0x0F. Repeat with rd asserted on the 17th push cycle -> overrun stays 0.
6. Assert HRESETn low during DATA of 0x7E -> all outputs at reset values. Then send 0x81 -> rdata=0x81.
